com_transfer_ctrl: RTL
======================

# com_transfer_ctrl

Communication-side transfer controller that sits directly upstream of the data-memory selector. It drives the selector's `status`, `com_addr`, `com_data_in` and `com_wr_en` inputs and consumes its `com_data_out`. It loads a block of data memory from a host byte stream, hands the memory to the processor for a run, then streams the block back to the host. Phases are sequenced by a single FSM.

## Interface
Parameters:
- `WORD_COUNT`, 64: 16-bit words per transfer, legal range 1..65535.
- `BASE_ADDR`, 16'h0000: first data-memory address of the block.

Ports:
- `clk` input 1: sole clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to begin a transfer; honoured only in IDLE.
- `rx_data` input 8: host byte in.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: controller accepts a byte this cycle.
- `tx_data` output 8: byte to host.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: host accepts the byte this cycle.
- `status` output 2: selector mode. 00 = com load or idle, 01 = processor owns memory, 10 = com readback.
- `com_addr` output 16: data-memory address.
- `com_data_in` output 16: write data.
- `com_wr_en` output 1: write strobe.
- `com_data_out` input 16: read data from the selector.
- `proc_start` output 1: one-cycle pulse that starts the processor.
- `proc_done` input 1: processor finished (level, sampled in RUN only).
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the readback completes.

## Operation
- FSM states: IDLE, LOAD_LO, LOAD_HI, WRITE, RUN, RD_ADDR, RD_WAIT, SEND_LO, SEND_HI, plus SUM_LO and SUM_HI when the checksum is enabled.
- Word index `idx` is 16 bits. It is cleared on leaving IDLE and when entering RD_ADDR from RUN. Address is `BASE_ADDR + idx`, truncated to 16 bits, so addresses wrap past 16'hFFFF.
- IDLE: `start` moves to LOAD_LO.
- LOAD_LO: `rx_ready`=1. A handshake stores the byte as the low byte and moves to LOAD_HI.
- LOAD_HI: `rx_ready`=1. A handshake stores the byte as the high byte and moves to WRITE.
- WRITE: `com_wr_en`=1 for exactly one cycle with `com_data_in`={hi,lo}. If `idx`==WORD_COUNT-1, go to RUN; otherwise increment `idx` and return to LOAD_LO.
- RUN: `status`=01 and `proc_start` pulses on the entry cycle. When `proc_done`=1, go to RD_ADDR.
- RD_ADDR: `status`=10 and `com_addr` is driven. Next state is RD_WAIT.
- RD_WAIT: capture `com_data_out` into the word register at the end of this cycle. Data-memory read latency is fixed at one cycle. Next state is SEND_LO.
- SEND_LO: `tx_data`=word[7:0]. On handshake go to SEND_HI.
- SEND_HI: `tx_data`=word[15:8]. On handshake, if this was the last word, finish; otherwise increment `idx` and go to RD_ADDR.
- Finish: go to IDLE, `done` pulses one cycle, and `status` returns to 00.
- `start` outside IDLE is ignored. `proc_done` outside RUN is ignored.
- `status` is 00 in IDLE, LOAD_* and WRITE.

## Timing
- Reset values: `status`=00, `com_addr`=BASE_ADDR, `com_data_in`=0, `com_wr_en`=0, `rx_ready`=0, `tx_valid`=0, `tx_data`=0, `proc_start`=0, `busy`=0, `done`=0. The FSM resets to IDLE and `idx` to 0.
- Reset asserted mid-transfer forces all of the above immediately, without waiting for a clock edge. No partial write strobe may survive.
- All outputs are registered.
- Byte-to-write latency: the write strobe is asserted in the cycle after the high-byte handshake.
- Readback: the first `tx_valid` is asserted 3 cycles after `proc_done` is sampled (RD_ADDR, RD_WAIT, then SEND_LO).
- Handshake rules:
  - A transfer occurs only when valid and ready are both high.
  - `tx_valid` is held high and `tx_data` held stable until `tx_ready`.
  - `tx_valid` has no dependency on `tx_ready`.
  - Back-to-back bytes are allowed with no idle cycle between them.
- WORD_COUNT=1: one load pair, one write, RUN, one readback pair.

## Configuration
- `COM_CHECKSUM_EN` defined:
  - After the last SEND_HI, the FSM passes through SUM_LO and then SUM_HI.
  - These states transmit a 16-bit checksum, low byte first, with the same valid/ready rules as data bytes.
  - The checksum is the sum, modulo 2^16, of all words read back.
  - `done` pulses after the SUM_HI handshake.
- `COM_CHECKSUM_EN` undefined: no trailer and no checksum logic. The stream is exactly 2×WORD_COUNT bytes.

## Test plan
- Reset defaults: with WORD_COUNT=4, assert `rst_n`=0 mid-LOAD_HI. Every output immediately takes its reset value, `busy`=0, and no `com_wr_en` is seen.
- Load: `start`, then bytes 34 12 78 56 BC 9A F0 DE. Writes 1234, 5678, 9ABC, DEF0 appear at BASE..BASE+3, one cycle each. Then `status`=01 and `proc_start` pulses once.
- Run gating: `proc_done` pulsed during LOAD is ignored. With `proc_done` held low for 50 cycles in RUN, `status` stays 01. Raising it gives `status`=10 on the next cycle.
- Readback with back-pressure: memory model returns 0xA55A and the following words. `tx_ready` toggles every other cycle. Required stream is 5A A5 …, with no byte dropped or duplicated and `tx_data` stable while stalled. Then `done` pulses and `status`=00.
- Address wrap: BASE_ADDR=16'hFFFE, WORD_COUNT=4. Writes go to FFFE, FFFF, 0000, 0001.
- `COM_CHECKSUM_EN`: words 0xFFFF and 0x0002 give trailer bytes 01 00. `start` asserted while busy has no effect.

Source files
------------

// File: rtl/com_transfer_ctrl_if.sv
// com_transfer_ctrl_if
// Bundles the host byte streams, data-memory selector port and processor
// handshake of the communication-side transfer controller.
//   start                  : one-cycle transfer request
//   rx_data/rx_valid/rx_ready : host -> controller byte stream
//   tx_data/tx_valid/tx_ready : controller -> host byte stream
//   status                 : selector mode (00 com/idle, 01 processor, 10 readback)
//   com_addr/com_data_in/com_wr_en/com_data_out : data-memory selector port
//   proc_start/proc_done   : processor run handshake
//   busy/done              : controller status
// Modports: master = controller side, slave = environment side.
interface com_transfer_ctrl_if;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [1:0]  status;
  logic [15:0] com_addr;
  logic [15:0] com_data_in;
  logic        com_wr_en;
  logic [15:0] com_data_out;
  logic        proc_start;
  logic        proc_done;
  logic        busy;
  logic        done;

  modport master (
    input  start, rx_data, rx_valid, tx_ready, com_data_out, proc_done,
    output rx_ready, tx_data, tx_valid, status, com_addr, com_data_in,
           com_wr_en, proc_start, busy, done
  );

  modport slave (
    output start, rx_data, rx_valid, tx_ready, com_data_out, proc_done,
    input  rx_ready, tx_data, tx_valid, status, com_addr, com_data_in,
           com_wr_en, proc_start, busy, done
  );
endinterface

// File: rtl/com_transfer_ctrl.sv
// com_transfer_ctrl
// Loads WORD_COUNT 16-bit words from a host byte stream into data memory
// starting at BASE_ADDR (low byte first), hands memory to the processor
// until proc_done, then streams the block back to the host low byte first.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : com_transfer_ctrl_if.master (byte streams, selector port,
//           processor handshake, busy/done)
// Optional feature macro: COM_CHECKSUM_EN -- appends a 16-bit trailer
// (sum modulo 2^16 of the words read back, low byte first) to the stream.
// Every output is a register loaded from the decode of the next state, so
// outputs line up with the state they belong to without combinational paths.
module com_transfer_ctrl #(
  parameter int unsigned WORD_COUNT = 64,
  parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
  input logic                 clk,
  input logic                 rst_n,
  com_transfer_ctrl_if.master bus
);

  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);

`ifdef COM_CHECKSUM_EN
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD_LO = 4'd1,
    LOAD_HI = 4'd2,
    WRITE   = 4'd3,
    RUN     = 4'd4,
    RD_ADDR = 4'd5,
    RD_WAIT = 4'd6,
    SEND_LO = 4'd7,
    SEND_HI = 4'd8,
    SUM_LO  = 4'd9,
    SUM_HI  = 4'd10
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD_LO = 4'd1,
    LOAD_HI = 4'd2,
    WRITE   = 4'd3,
    RUN     = 4'd4,
    RD_ADDR = 4'd5,
    RD_WAIT = 4'd6,
    SEND_LO = 4'd7,
    SEND_HI = 4'd8
  } state_t;
`endif

  state_t      state_r, state_s;
  logic [15:0] idx_r, idx_s;
  logic [7:0]  lo_r, lo_s;
  logic [15:0] word_r, word_s;
`ifdef COM_CHECKSUM_EN
  logic [15:0] sum_r, sum_s;
`endif

  logic        rx_hs_s, tx_hs_s, last_s;

  logic        rx_ready_r, rx_ready_s;
  logic [7:0]  tx_data_r, tx_data_s;
  logic        tx_valid_r, tx_valid_s;
  logic [1:0]  status_r, status_s;
  logic [15:0] com_addr_r, com_addr_s;
  logic [15:0] com_data_in_r, com_data_in_s;
  logic        com_wr_en_r, com_wr_en_s;
  logic        proc_start_r, proc_start_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;

  // Next-state, datapath and next-output decode for the transfer sequencer
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    lo_s    = lo_r;
    word_s  = word_r;
`ifdef COM_CHECKSUM_EN
    sum_s   = sum_r;
`endif
    // rx_ready/tx_valid registers mirror the state, so they are the handshake qualifiers
    rx_hs_s = bus.rx_valid && rx_ready_r;
    tx_hs_s = tx_valid_r && bus.tx_ready;
    last_s  = (idx_r == LAST_IDX);

    case (state_r)
      IDLE: begin
        if (bus.start) begin
          idx_s   = 16'd0;
          state_s = LOAD_LO;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_LO: begin
        if (rx_hs_s) begin
          lo_s    = bus.rx_data;
          state_s = LOAD_HI;
        end else begin
          state_s = LOAD_LO;
        end
      end
      LOAD_HI: begin
        if (rx_hs_s) begin
          word_s  = {bus.rx_data, lo_r};
          state_s = WRITE;
        end else begin
          state_s = LOAD_HI;
        end
      end
      WRITE: begin
        if (last_s) begin
          state_s = RUN;
        end else begin
          idx_s   = idx_r + 16'd1;
          state_s = LOAD_LO;
        end
      end
      RUN: begin
        if (bus.proc_done) begin
          idx_s   = 16'd0;
`ifdef COM_CHECKSUM_EN
          sum_s   = 16'd0;
`endif
          state_s = RD_ADDR;
        end else begin
          state_s = RUN;
        end
      end
      RD_ADDR: begin
        state_s = RD_WAIT;
      end
      RD_WAIT: begin
        // read data is valid one cycle after the address was presented
        word_s  = bus.com_data_out;
`ifdef COM_CHECKSUM_EN
        sum_s   = sum_r + bus.com_data_out;
`endif
        state_s = SEND_LO;
      end
      SEND_LO: begin
        if (tx_hs_s) begin
          state_s = SEND_HI;
        end else begin
          state_s = SEND_LO;
        end
      end
      SEND_HI: begin
        if (tx_hs_s) begin
          if (last_s) begin
`ifdef COM_CHECKSUM_EN
            state_s = SUM_LO;
`else
            state_s = IDLE;
`endif
          end else begin
            idx_s   = idx_r + 16'd1;
            state_s = RD_ADDR;
          end
        end else begin
          state_s = SEND_HI;
        end
      end
`ifdef COM_CHECKSUM_EN
      SUM_LO: begin
        if (tx_hs_s) begin
          state_s = SUM_HI;
        end else begin
          state_s = SUM_LO;
        end
      end
      SUM_HI: begin
        if (tx_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = SUM_HI;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase

    // Output values for the state being entered
    busy_s       = (state_s != IDLE);
    rx_ready_s   = (state_s == LOAD_LO) || (state_s == LOAD_HI);
    com_wr_en_s  = (state_s == WRITE);
    proc_start_s = (state_s == RUN) && (state_r != RUN);
    done_s       = (state_s == IDLE) && (state_r != IDLE);
    com_addr_s   = BASE_ADDR + idx_s;
    if (state_s == WRITE) begin
      com_data_in_s = word_s;
    end else begin
      com_data_in_s = com_data_in_r;
    end

    status_s   = 2'b00;
    tx_valid_s = 1'b0;
    tx_data_s  = tx_data_r;
    case (state_s)
      RUN: begin
        status_s = 2'b01;
      end
      RD_ADDR, RD_WAIT: begin
        status_s = 2'b10;
      end
      SEND_LO: begin
        status_s   = 2'b10;
        tx_valid_s = 1'b1;
        tx_data_s  = word_s[7:0];
      end
      SEND_HI: begin
        status_s   = 2'b10;
        tx_valid_s = 1'b1;
        tx_data_s  = word_s[15:8];
      end
`ifdef COM_CHECKSUM_EN
      SUM_LO: begin
        status_s   = 2'b10;
        tx_valid_s = 1'b1;
        tx_data_s  = sum_s[7:0];
      end
      SUM_HI: begin
        status_s   = 2'b10;
        tx_valid_s = 1'b1;
        tx_data_s  = sum_s[15:8];
      end
`endif
      default: begin
        status_s = 2'b00;
      end
    endcase
  end

  // State, datapath and output registers; reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      idx_r         <= 16'd0;
      lo_r          <= 8'd0;
      word_r        <= 16'd0;
`ifdef COM_CHECKSUM_EN
      sum_r         <= 16'd0;
`endif
      rx_ready_r    <= 1'b0;
      tx_data_r     <= 8'd0;
      tx_valid_r    <= 1'b0;
      status_r      <= 2'b00;
      com_addr_r    <= BASE_ADDR;
      com_data_in_r <= 16'd0;
      com_wr_en_r   <= 1'b0;
      proc_start_r  <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      lo_r          <= lo_s;
      word_r        <= word_s;
`ifdef COM_CHECKSUM_EN
      sum_r         <= sum_s;
`endif
      rx_ready_r    <= rx_ready_s;
      tx_data_r     <= tx_data_s;
      tx_valid_r    <= tx_valid_s;
      status_r      <= status_s;
      com_addr_r    <= com_addr_s;
      com_data_in_r <= com_data_in_s;
      com_wr_en_r   <= com_wr_en_s;
      proc_start_r  <= proc_start_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
    end
  end

  assign bus.rx_ready    = rx_ready_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.tx_valid    = tx_valid_r;
  assign bus.status      = status_r;
  assign bus.com_addr    = com_addr_r;
  assign bus.com_data_in = com_data_in_r;
  assign bus.com_wr_en   = com_wr_en_r;
  assign bus.proc_start  = proc_start_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule
